// File: rtl/pipelined_ctrl_pipe_pkg.sv
// Shared encodings and the per-stage control bundle carried down the
// Execute/Memory/Writeback registers of the RV32I core.
package pipelined_ctrl_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       branch_neg;
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic [4:0] rd;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  function automatic logic is_load(input ctrl_bundle_t b);
    return b.valid && (b.result_src == RES_MEM);
  endfunction

endpackage

// File: rtl/pipelined_ctrl_pipe_if.sv
// Decode-side control inputs and per-stage control/hazard outputs.
interface pipelined_ctrl_pipe_if;
  logic        reg_write_d;
  logic [1:0]  result_src_d;
  logic        mem_write_d;
  logic        jump_d;
  logic        branch_d;
  logic        branch_neg_d;
  logic [2:0]  alu_ctrl_d;
  logic        alu_src_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        zero_e;

  logic [2:0]  alu_ctrl_e;
  logic        alu_src_e;
  logic        pc_src_e;
  logic [4:0]  rd_e, rd_m, rd_w;
  logic        mem_write_m;
  logic        reg_write_m;
  logic [1:0]  result_src_m;
  logic        reg_write_w;
  logic [1:0]  result_src_w;
  logic        stall_f, stall_d;
  logic        flush_d, flush_e;
  logic [31:0] retired;

  modport master (
    output reg_write_d, result_src_d, mem_write_d, jump_d, branch_d, branch_neg_d,
           alu_ctrl_d, alu_src_d, rs1_d, rs2_d, rd_d, zero_e,
    input  alu_ctrl_e, alu_src_e, pc_src_e, rd_e, rd_m, rd_w, mem_write_m,
           reg_write_m, result_src_m, reg_write_w, result_src_w,
           stall_f, stall_d, flush_d, flush_e, retired
  );

  modport slave (
    input  reg_write_d, result_src_d, mem_write_d, jump_d, branch_d, branch_neg_d,
           alu_ctrl_d, alu_src_d, rs1_d, rs2_d, rd_d, zero_e,
    output alu_ctrl_e, alu_src_e, pc_src_e, rd_e, rd_m, rd_w, mem_write_m,
           reg_write_m, result_src_m, reg_write_w, result_src_w,
           stall_f, stall_d, flush_d, flush_e, retired
  );
endinterface

// File: rtl/pipelined_ctrl_pipe_stage_reg.sv
// One pipeline register of the control bundle; an invalid bundle is always
// stored as an all-zero bubble so downstream fields never carry stale bits.
module ctrl_stage_reg
  import pipelined_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  ctrl_bundle_t d,
  output ctrl_bundle_t q
);
  ctrl_bundle_t bundle_q, bundle_d;

  always_comb begin
    bundle_d = d;
    if (flush || !d.valid) bundle_d = BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (rst) bundle_q <= BUBBLE;
    else     bundle_q <= bundle_d;
  end

  assign q = bundle_q;
endmodule

// File: rtl/pipelined_ctrl_pipe.sv
// Control pipeline D->E->M->W with branch resolution in Execute, load-use
// hazard detection, fetch/decode stall-flush generation and a retire counter.
module pipelined_ctrl_pipe
  import pipelined_ctrl_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  pipelined_ctrl_pipe_if.slave bus
);
  ctrl_bundle_t d_b, e_b, m_b, w_b;
  logic         pc_src, lw_stall, flush_e;
  logic [31:0]  retired_q, retired_d;
  logic         unused_w;

  always_comb begin
    d_b            = BUBBLE;
    d_b.valid      = 1'b1;
    d_b.reg_write  = bus.reg_write_d;
    d_b.result_src = bus.result_src_d;
    d_b.mem_write  = bus.mem_write_d;
    d_b.jump       = bus.jump_d;
    d_b.branch     = bus.branch_d;
    d_b.branch_neg = bus.branch_neg_d;
    d_b.alu_ctrl   = bus.alu_ctrl_d;
    d_b.alu_src    = bus.alu_src_d;
    d_b.rd         = bus.rd_d;
  end

  ctrl_stage_reg u_e (.clk(clk), .rst(rst), .flush(flush_e), .d(d_b), .q(e_b));
  ctrl_stage_reg u_m (.clk(clk), .rst(rst), .flush(1'b0),    .d(e_b), .q(m_b));
  ctrl_stage_reg u_w (.clk(clk), .rst(rst), .flush(1'b0),    .d(m_b), .q(w_b));

  // A redirect outranks a load-use stall: the dependent decode slot is
  // being flushed anyway, so holding fetch would only lose the target.
  always_comb begin
    pc_src   = e_b.valid & (e_b.jump | (e_b.branch & (bus.zero_e ^ e_b.branch_neg)));
    lw_stall = is_load(e_b) & (e_b.rd != 5'd0) &
               ((e_b.rd == bus.rs1_d) | (e_b.rd == bus.rs2_d));
    flush_e  = pc_src | lw_stall;
  end

  always_comb retired_d = retired_q + {31'd0, w_b.valid};

  always_ff @(posedge clk) begin
    if (rst) retired_q <= '0;
    else     retired_q <= retired_d;
  end

  assign bus.alu_ctrl_e   = e_b.alu_ctrl;
  assign bus.alu_src_e    = e_b.alu_src;
  assign bus.rd_e         = e_b.rd;
  assign bus.pc_src_e     = pc_src;
  assign bus.rd_m         = m_b.rd;
  assign bus.mem_write_m  = m_b.mem_write;
  assign bus.reg_write_m  = m_b.reg_write;
  assign bus.result_src_m = m_b.result_src;
  assign bus.rd_w         = w_b.rd;
  assign bus.reg_write_w  = w_b.reg_write;
  assign bus.result_src_w = w_b.result_src;
  assign bus.stall_f      = lw_stall & ~pc_src;
  assign bus.stall_d      = lw_stall & ~pc_src;
  assign bus.flush_d      = pc_src;
  assign bus.flush_e      = flush_e;
  assign bus.retired      = retired_q;

  assign unused_w = ^{w_b.mem_write, w_b.jump, w_b.branch, w_b.branch_neg,
                      w_b.alu_ctrl, w_b.alu_src};
endmodule

// File: tb/tb_pipelined_ctrl_pipe.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared each cycle against a slot-level reference model.
module tb_pipelined_ctrl_pipe;
  logic clk = 1'b0;
  logic rst;
  logic chk_en = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  pipelined_ctrl_pipe_if bus ();
  pipelined_ctrl_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       v;
    logic       rw;
    logic [1:0] rs;
    logic       mw, j, b, bn;
    logic [2:0] alu;
    logic       asrc;
    logic [4:0] rd;
  } ent_t;

  // slot[0]=Execute, slot[1]=Memory, slot[2]=Writeback
  ent_t        slot [3];
  logic [31:0] m_ret;
  logic        c_pc, c_lw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic f_pc(input ent_t e, input logic z);
    return e.v && (e.j || (e.b && (z != e.bn)));
  endfunction

  function automatic logic f_lw(input ent_t e, input logic [4:0] r1, input logic [4:0] r2);
    return e.v && e.rs == 2'b01 && e.rd != 5'd0 && (e.rd == r1 || e.rd == r2);
  endfunction

  function automatic ent_t cur_in();
    ent_t e;
    e.v = 1'b1; e.rw = bus.reg_write_d; e.rs = bus.result_src_d; e.mw = bus.mem_write_d;
    e.j = bus.jump_d; e.b = bus.branch_d; e.bn = bus.branch_neg_d;
    e.alu = bus.alu_ctrl_d; e.asrc = bus.alu_src_d; e.rd = bus.rd_d;
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) slot[i] <= '0;
      m_ret <= '0;
    end else begin
      m_ret   <= m_ret + (slot[2].v ? 32'd1 : 32'd0);
      slot[2] <= slot[1];
      slot[1] <= slot[0];
      slot[0] <= (f_pc(slot[0], bus.zero_e) || f_lw(slot[0], bus.rs1_d, bus.rs2_d))
                 ? ent_t'('0) : cur_in();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      c_pc = f_pc(slot[0], bus.zero_e);
      c_lw = f_lw(slot[0], bus.rs1_d, bus.rs2_d);
      chk("alu_ctrl_e",   32'(bus.alu_ctrl_e),   32'(slot[0].alu));
      chk("alu_src_e",    32'(bus.alu_src_e),    32'(slot[0].asrc));
      chk("rd_e",         32'(bus.rd_e),         32'(slot[0].rd));
      chk("pc_src_e",     32'(bus.pc_src_e),     32'(c_pc));
      chk("rd_m",         32'(bus.rd_m),         32'(slot[1].rd));
      chk("mem_write_m",  32'(bus.mem_write_m),  32'(slot[1].mw));
      chk("reg_write_m",  32'(bus.reg_write_m),  32'(slot[1].rw));
      chk("result_src_m", 32'(bus.result_src_m), 32'(slot[1].rs));
      chk("rd_w",         32'(bus.rd_w),         32'(slot[2].rd));
      chk("reg_write_w",  32'(bus.reg_write_w),  32'(slot[2].rw));
      chk("result_src_w", 32'(bus.result_src_w), 32'(slot[2].rs));
      chk("stall_f",      32'(bus.stall_f),      32'(c_lw && !c_pc));
      chk("stall_d",      32'(bus.stall_d),      32'(c_lw && !c_pc));
      chk("flush_d",      32'(bus.flush_d),      32'(c_pc));
      chk("flush_e",      32'(bus.flush_e),      32'(c_pc || c_lw));
      chk("retired",      bus.retired,           m_ret);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic j, input logic b, input logic bn,
                       input logic [2:0] alu, input logic asrc,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    bus.reg_write_d = rw; bus.result_src_d = rs; bus.mem_write_d = mw;
    bus.jump_d = j; bus.branch_d = b; bus.branch_neg_d = bn;
    bus.alu_ctrl_d = alu; bus.alu_src_d = asrc;
    bus.rs1_d = r1; bus.rs2_d = r2; bus.rd_d = rd;
  endtask

  task automatic drive_rand();
    drive(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
          3'($urandom), 1'($urandom),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    bus.zero_e = 1'($urandom);
  endtask

  task automatic nop(input logic [4:0] rd);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, rd);
  endtask

  initial begin
    rst = 1'b1;
    drive_rand();
    tick();
    chk_en = 1'b1;
    drive_rand();
    tick();

    // Reset state, first cycle after release
    rst = 1'b0;
    bus.zero_e = 1'b0;
    nop(5'd1);
    #1;
    chk("rst rd_e",    32'(bus.rd_e),    32'd0);
    chk("rst rd_w",    32'(bus.rd_w),    32'd0);
    chk("rst stall_f", 32'(bus.stall_f), 32'd0);
    chk("rst flush_e", 32'(bus.flush_e), 32'd0);
    chk("rst retired", bus.retired,      32'd0);

    // Straight-line: four adds rd=1..4
    for (int k = 1; k <= 4; k++) begin
      nop(5'(k));
      tick();
      if (k >= 3) chk("line rd_w", 32'(bus.rd_w), 32'(k - 2));
    end
    nop(5'd0);
    tick(); chk("line rd_w", 32'(bus.rd_w), 32'd3);
    tick(); chk("line rd_w", 32'(bus.rd_w), 32'd4);
    tick(); chk("line retired", bus.retired, 32'd4);

    // Load-use on rd=5
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd5);
    tick();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 5'd5, 5'd0, 5'd6);
    #1;
    chk("lu stall_f", 32'(bus.stall_f), 32'd1);
    chk("lu stall_d", 32'(bus.stall_d), 32'd1);
    chk("lu flush_e", 32'(bus.flush_e), 32'd1);
    chk("lu flush_d", 32'(bus.flush_d), 32'd0);
    tick();
    chk("lu bubble rd_e", 32'(bus.rd_e),    32'd0);
    chk("lu stall drop",  32'(bus.stall_f), 32'd0);
    tick();
    chk("lu dep rd_e",  32'(bus.rd_e),       32'd6);
    chk("lu dep alu_e", 32'(bus.alu_ctrl_e), 32'd2);

    // Load to x0: no stall
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd6);
    #1;
    chk("lu x0 stall_f", 32'(bus.stall_f), 32'd0);
    chk("lu x0 flush_e", 32'(bus.flush_e), 32'd0);
    tick();
    chk("lu x0 rd_e", 32'(bus.rd_e), 32'd6);

    // Taken branch (beq, zero=1)
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    bus.zero_e = 1'b1;
    nop(5'd7);
    #1;
    chk("br pc_src",  32'(bus.pc_src_e), 32'd1);
    chk("br flush_d", 32'(bus.flush_d),  32'd1);
    chk("br flush_e", 32'(bus.flush_e),  32'd1);
    chk("br stall_f", 32'(bus.stall_f),  32'd0);
    tick();
    chk("br bubble rd_e", 32'(bus.rd_e),     32'd0);
    chk("br bubble pc",   32'(bus.pc_src_e), 32'd0);

    // Not taken (zero=0)
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    bus.zero_e = 1'b0;
    nop(5'd7);
    #1;
    chk("nt pc_src", 32'(bus.pc_src_e), 32'd0);
    tick();
    chk("nt rd_e", 32'(bus.rd_e), 32'd7);

    // Inverted branch (bne, zero=0): taken
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    nop(5'd8);
    #1;
    chk("bne pc_src", 32'(bus.pc_src_e), 32'd1);
    tick();
    chk("bne rd_e", 32'(bus.rd_e), 32'd0);

    // Malformed load+jump with matching rs1: redirect wins
    drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 5'd0, 5'd0, 5'd5);
    tick();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd5, 5'd0, 5'd9);
    #1;
    chk("cf stall_f", 32'(bus.stall_f), 32'd0);
    chk("cf stall_d", 32'(bus.stall_d), 32'd0);
    chk("cf flush_d", 32'(bus.flush_d), 32'd1);
    chk("cf flush_e", 32'(bus.flush_e), 32'd1);
    tick();
    chk("cf rd_e", 32'(bus.rd_e), 32'd0);

    // Reset with two instructions in flight: neither counted
    rst = 1'b1; nop(5'd0); tick();
    rst = 1'b0;
    nop(5'd10); tick();
    nop(5'd11); tick();
    rst = 1'b1; nop(5'd12); tick();
    rst = 1'b0; nop(5'd13);
    #1;
    chk("mr retired", bus.retired, 32'd0);
    chk("mr rd_e",    32'(bus.rd_e), 32'd0);
    chk("mr rd_m",    32'(bus.rd_m), 32'd0);
    tick(); tick(); tick();
    chk("mr retired late", bus.retired,    32'd0);
    chk("mr rd_w",         32'(bus.rd_w), 32'd13);

    // Randomized run with occasional resets
    repeat (3000) begin
      rst = ($urandom_range(0, 99) == 0);
      drive_rand();
      tick();
    end
    rst = 1'b0;
    repeat (4) begin
      nop(5'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
